// File: rtl/icache_axi_refill_pkg.sv
// ---------------------------------------------------------------------------
// icache_axi_refill_pkg
//   Shared constants and types for the instruction-cache AXI refill engine:
//   AXI4 burst/size/response encodings, cache line geometry and the refill
//   FSM state encoding.
// ---------------------------------------------------------------------------
package icache_axi_refill_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    localparam int LINE_WORDS = 8;
    localparam int LINE_W     = 32 * LINE_WORDS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } refill_state_t;

endpackage

// File: rtl/icache_axi_refill.sv
// ---------------------------------------------------------------------------
// icache_axi_refill
//   Memory-side responder for the ICache line-refill interface. A level-held
//   refill request (req_ren_i + req_araddr_i) launches one 8-beat, 32-bit
//   AXI4 read burst; the beats are assembled into a 256-bit line which is
//   returned with a single-cycle line_rvalid_o pulse.
//
// Configuration macro:
//   CRITICAL_WORD_FIRST_EN - issue a WRAP burst starting at the missing word
//                            instead of an INCR burst from the line base.
//                            The returned line layout is identical.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_ren_i, req_araddr_i  refill request (held until line_rvalid_o)
//   line_rvalid_o            one-cycle pulse: line_rdata_o / line_err_o valid
//   line_rdata_o             word i at bits [32i+31:32i]
//   line_err_o               bad rresp or rlast mismatch in the burst
//   m_ar*                    AXI4 read address channel (master)
//   m_r*                     AXI4 read data channel (master)
//   dbg_state_o              current FSM state (refill_state_t encoding)
//
// Handshake rule for both AXI channels: a transfer happens on a rising clk
// edge where valid and ready are both high; valid, once raised, is held with
// stable payload until that transfer.
// ---------------------------------------------------------------------------
module icache_axi_refill
    import icache_axi_refill_pkg::*;
#(
    parameter int AXI_ID_W   = 4,
    parameter int AXI_ID     = 0,
    parameter int LINE_WORDS = icache_axi_refill_pkg::LINE_WORDS
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    req_ren_i,
    input  logic [31:0]             req_araddr_i,

    output logic                    line_rvalid_o,
    output logic [32*LINE_WORDS-1:0] line_rdata_o,
    output logic                    line_err_o,

    output logic [AXI_ID_W-1:0]     m_arid,
    output logic [31:0]             m_araddr,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    output logic                    m_arvalid,
    input  logic                    m_arready,

    input  logic [AXI_ID_W-1:0]     m_rid,
    input  logic [31:0]             m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    input  logic                    m_rvalid,
    output logic                    m_rready,

    output logic [1:0]              dbg_state_o
);

    localparam int CNT_W = $clog2(LINE_WORDS);

    refill_state_t     state_q;
    logic [31:5]       line_addr_q;
    logic [31:0]       araddr_q;
    logic              arvalid_q;
    logic              rready_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  start_q;
    logic              err_q;
    logic [31:0]       line_q [LINE_WORDS];

    logic [CNT_W-1:0]  beat_slot;
    logic              cnt_last;
    logic              line_hit;

    // Slot index wraps naturally because LINE_WORDS is a power of two.
    assign beat_slot = cnt_q + start_q;
    assign cnt_last  = (cnt_q == CNT_W'(LINE_WORDS - 1));

    // The line is only delivered if the requester still wants this exact
    // line in the DONE cycle; a withdrawn or redirected request drops it.
    assign line_hit = (state_q == ST_DONE) && req_ren_i &&
                      (req_araddr_i[31:5] == line_addr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            line_addr_q <= '0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            cnt_q       <= '0;
            start_q     <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_ren_i) begin
                        line_addr_q <= req_araddr_i[31:5];
`ifdef CRITICAL_WORD_FIRST_EN
                        araddr_q    <= {req_araddr_i[31:2], 2'b00};
                        start_q     <= req_araddr_i[4:2];
`else
                        araddr_q    <= {req_araddr_i[31:5], 5'b0};
                        start_q     <= '0;
`endif
                        arvalid_q   <= 1'b1;
                        cnt_q       <= '0;
                        err_q       <= 1'b0;
                        state_q     <= ST_AR;
                    end
                end

                ST_AR: begin
                    // Once issued, AR is never withdrawn even if ren drops.
                    if (m_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        cnt_q     <= '0;
                        err_q     <= 1'b0;
                        state_q   <= ST_R;
                    end
                end

                ST_R: begin
                    if (m_rvalid && rready_q) begin
                        line_q[beat_slot] <= m_rdata;
                        cnt_q             <= cnt_q + 1'b1;
                        // Bad response, rlast too early, or rlast missing on
                        // the final expected beat all flag the line.
                        if ((m_rresp != AXI_RESP_OKAY) || (m_rlast != cnt_last)) begin
                            err_q <= 1'b1;
                        end
                        if (m_rlast || cnt_last) begin
                            rready_q <= 1'b0;
                            state_q  <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LINE_WORDS; gi++) begin : g_pack
            assign line_rdata_o[32*gi +: 32] = line_q[gi];
        end
    endgenerate

    assign line_rvalid_o = line_hit;
    assign line_err_o    = line_hit & err_q;

    assign m_arid    = AXI_ID_W'(AXI_ID);
    assign m_araddr  = araddr_q;
    assign m_arlen   = 8'(LINE_WORDS - 1);
    assign m_arsize  = AXI_SIZE_4B;
`ifdef CRITICAL_WORD_FIRST_EN
    assign m_arburst = AXI_BURST_WRAP;
`else
    assign m_arburst = AXI_BURST_INCR;
`endif
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;

    assign dbg_state_o = state_q;

    // rid is not checked; low address bits only matter for the WRAP start.
    logic unused_ok;
    assign unused_ok = ^{m_rid, req_araddr_i[4:0]};

endmodule

// File: tb/tb_icache_axi_refill.sv
// ---------------------------------------------------------------------------
// tb_icache_axi_refill
//   Directed self-checking bench for icache_axi_refill. Acts as both the
//   ICache requester and a simple AXI slave. Honors CRITICAL_WORD_FIRST_EN
//   for the expected AR address, burst type and beat ordering.
// ---------------------------------------------------------------------------
module tb_icache_axi_refill;

    localparam int AXI_ID_W = 4;

`ifdef CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic                req_ren_i;
    logic [31:0]         req_araddr_i;
    logic                line_rvalid_o;
    logic [255:0]        line_rdata_o;
    logic                line_err_o;
    logic [AXI_ID_W-1:0] m_arid;
    logic [31:0]         m_araddr;
    logic [7:0]          m_arlen;
    logic [2:0]          m_arsize;
    logic [1:0]          m_arburst;
    logic                m_arvalid;
    logic                m_arready;
    logic [AXI_ID_W-1:0] m_rid;
    logic [31:0]         m_rdata;
    logic [1:0]          m_rresp;
    logic                m_rlast;
    logic                m_rvalid;
    logic                m_rready;
    logic [1:0]          dbg_state_o;

    icache_axi_refill #(.AXI_ID_W(AXI_ID_W), .AXI_ID(0)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_ren_i     (req_ren_i),
        .req_araddr_i  (req_araddr_i),
        .line_rvalid_o (line_rvalid_o),
        .line_rdata_o  (line_rdata_o),
        .line_err_o    (line_err_o),
        .m_arid        (m_arid),
        .m_araddr      (m_araddr),
        .m_arlen       (m_arlen),
        .m_arsize      (m_arsize),
        .m_arburst     (m_arburst),
        .m_arvalid     (m_arvalid),
        .m_arready     (m_arready),
        .m_rid         (m_rid),
        .m_rdata       (m_rdata),
        .m_rresp       (m_rresp),
        .m_rlast       (m_rlast),
        .m_rvalid      (m_rvalid),
        .m_rready      (m_rready),
        .dbg_state_o   (dbg_state_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_pass = 0;
    int n_total = 0;
    logic [31:0] beats [8];   // data the slave returns, in beat order
    logic [31:0] exp_w [8];   // expected line, by slot

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [255:0] pack_exp();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = exp_w[i];
        return v;
    endfunction

    // Address-aware memory: word i of the line holds base+i; beats come back
    // in wrap order from the critical word when WRAP bursts are in use.
    task automatic load_mem(input logic [31:0] base, input logic [31:0] addr);
        logic [2:0] st;
        st = CWF ? addr[4:2] : 3'd0;
        for (int k = 0; k < 8; k++) begin
            beats[k] = base + 32'((st + 3'(k)) & 3'h7);
            exp_w[k] = base + 32'(k);
        end
    endtask

    // One complete refill: request, AR (with optional backpressure), beats,
    // then checks in the DONE cycle and the following IDLE cycle.
    task automatic refill(input string name, input logic [31:0] addr,
                          input logic [31:0] exp_araddr, input int ar_wait,
                          input int n_beats, input int err_beat, input int drop_beat,
                          input bit exp_valid, input bit exp_err, input int exp_lat);
        int lat;
        lat = 0;
        req_ren_i    = 1'b1;
        req_araddr_i = addr;
        tick(); lat++;
        chk({name, ".arvalid"}, 256'(m_arvalid), 256'(1'b1));
        chk({name, ".araddr"},  256'(m_araddr), 256'(exp_araddr));
        for (int w = 0; w < ar_wait; w++) begin
            m_arready = 1'b0;
            tick(); lat++;
            chk({name, ".arvalid_hold"}, 256'(m_arvalid), 256'(1'b1));
            chk({name, ".araddr_hold"},  256'(m_araddr), 256'(exp_araddr));
        end
        m_arready = 1'b1;
        tick(); lat++;
        m_arready = 1'b0;
        for (int k = 0; k < n_beats; k++) begin
            chk({name, ".rready"}, 256'(m_rready), 256'(1'b1));
            m_rvalid = 1'b1;
            m_rdata  = beats[k];
            m_rresp  = (k == err_beat) ? 2'b10 : 2'b00;
            m_rlast  = (k == n_beats - 1);
            if (k == drop_beat) req_ren_i = 1'b0;
            tick(); lat++;
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rresp  = 2'b00;
        chk({name, ".latency"}, 256'(lat), 256'(exp_lat));
        chk({name, ".rvalid"},  256'(line_rvalid_o), 256'(exp_valid));
        chk({name, ".err"},     256'(line_err_o), 256'(exp_valid & exp_err));
        if (exp_valid) chk({name, ".data"}, line_rdata_o, pack_exp());
        req_ren_i = 1'b0;
        tick();
        chk({name, ".idle"},        256'(dbg_state_o), 256'(2'd0));
        chk({name, ".pulse_1cyc"},  256'(line_rvalid_o), 256'(1'b0));
        if (exp_valid) chk({name, ".data_stable"}, line_rdata_o, pack_exp());
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst          = 1'b1;
        req_ren_i    = 1'b0;
        req_araddr_i = '0;
        m_arready    = 1'b0;
        m_rid        = '0;
        m_rdata      = '0;
        m_rresp      = 2'b00;
        m_rlast      = 1'b0;
        m_rvalid     = 1'b0;
        tick(); tick(); tick();

        chk("rst.arvalid", 256'(m_arvalid), 256'(1'b0));
        chk("rst.rready",  256'(m_rready), 256'(1'b0));
        chk("rst.rvalid",  256'(line_rvalid_o), 256'(1'b0));
        chk("rst.err",     256'(line_err_o), 256'(1'b0));
        chk("rst.rdata",   line_rdata_o, 256'(0));
        chk("rst.araddr",  256'(m_araddr), 256'(0));
        chk("rst.state",   256'(dbg_state_o), 256'(2'd0));
        chk("const.arlen",  256'(m_arlen), 256'(8'd7));
        chk("const.arsize", 256'(m_arsize), 256'(3'b010));
        chk("const.arid",   256'(m_arid), 256'(4'd0));
        chk("const.arburst", 256'(m_arburst), 256'(CWF ? 2'b10 : 2'b01));
        rst = 1'b0;
        tick();

        // Basic refill, zero-wait slave, pulse at N+10.
        load_mem(32'h0000_00A0, 32'h1FC0_0024);
        refill("incr", 32'h1FC0_0024, CWF ? 32'h1FC0_0024 : 32'h1FC0_0020,
               0, 8, -1, -1, 1'b1, 1'b0, 10);

        // AR backpressure: pulse delayed by exactly 5 cycles.
        load_mem(32'h0000_0A50, 32'h1FC0_0024);
        refill("arwait", 32'h1FC0_0024, CWF ? 32'h1FC0_0024 : 32'h1FC0_0020,
               5, 8, -1, -1, 1'b1, 1'b0, 15);

        // Request withdrawn during beat 3: burst still runs, no pulse.
        load_mem(32'h0000_0F00, 32'h0000_4000);
        refill("withdraw", 32'h0000_4000, 32'h0000_4000,
               0, 8, -1, 3, 1'b0, 1'b0, 10);

        // SLVERR on beat 5, then a clean burst reports no error.
        load_mem(32'h0000_00C0, 32'h0000_2000);
        refill("slverr", 32'h0000_2000, 32'h0000_2000,
               0, 8, 5, -1, 1'b1, 1'b1, 10);
        load_mem(32'h0000_00D0, 32'h0000_2040);
        refill("clean", 32'h0000_2040, 32'h0000_2040,
               0, 8, -1, -1, 1'b1, 1'b0, 10);

        // Early rlast on the 6th beat: slots 6,7 keep the previous line.
        load_mem(32'h0000_00E0, 32'h0000_3000);
        exp_w[6] = 32'h0000_00D6;
        exp_w[7] = 32'h0000_00D7;
        refill("early_rlast", 32'h0000_3000, 32'h0000_3000,
               0, 6, -1, -1, 1'b1, 1'b1, 8);

        // Beat-order data 0xB0..0xB7 for a miss on word 5.
        for (int k = 0; k < 8; k++) beats[k] = 32'h0000_00B0 + 32'(k);
        if (CWF) begin
            exp_w[5] = 32'hB0; exp_w[6] = 32'hB1; exp_w[7] = 32'hB2;
            exp_w[0] = 32'hB3; exp_w[1] = 32'hB4; exp_w[2] = 32'hB5;
            exp_w[3] = 32'hB6; exp_w[4] = 32'hB7;
        end else begin
            for (int k = 0; k < 8; k++) exp_w[k] = 32'h0000_00B0 + 32'(k);
        end
        refill("cwf", 32'h0000_0014, CWF ? 32'h0000_0014 : 32'h0000_0000,
               0, 8, -1, -1, 1'b1, 1'b0, 10);

        // Reset asserted on beat 4 of a burst.
        req_ren_i    = 1'b1;
        req_araddr_i = 32'h0000_5000;
        tick();
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_rvalid = 1'b1;
            m_rdata  = 32'h0000_0700 + 32'(k);
            tick();
        end
        m_rdata = 32'h0000_0704;
        rst     = 1'b1;
        tick();
        rst       = 1'b0;
        m_rvalid  = 1'b0;
        req_ren_i = 1'b0;
        chk("midrst.arvalid", 256'(m_arvalid), 256'(1'b0));
        chk("midrst.rready",  256'(m_rready), 256'(1'b0));
        chk("midrst.rvalid",  256'(line_rvalid_o), 256'(1'b0));
        chk("midrst.state",   256'(dbg_state_o), 256'(2'd0));
        chk("midrst.rdata",   line_rdata_o, 256'(0));
        tick();

        // Fresh request after reset completes normally.
        load_mem(32'h0000_0110, 32'h0000_6000);
        refill("post_rst", 32'h0000_6000, 32'h0000_6000,
               0, 8, -1, -1, 1'b1, 1'b0, 10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/icache_axi_refill.md
Name: icache_axi_refill

Overview:
- Memory-side responder for the instruction cache's line-refill interface.
- Accepts a level-held refill request (ren + physical address) and issues one 8-beat, 32-bit AXI4 read burst.
- Assembles the beats into a 256-bit line and returns it with a single-cycle valid pulse.
- Sits between the ICache miss path and the AXI interconnect.

Parameters:
- AXI_ID_W, 4, width of arid/rid.
- AXI_ID, 0, constant ID driven on arid; rid is not checked.
- LINE_WORDS, 8, words per cache line (fixed; line = 32*LINE_WORDS bits).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_ren_i  in  1  refill request; held high until line_rvalid_o is seen, then dropped combinationally by requester.
- req_araddr_i  in  32  physical address of missing instruction.
- line_rvalid_o  out  1  one-cycle pulse: line_rdata_o valid.
- line_rdata_o  out  256  word i at bits [32i+31:32i], i = address bits [4:2].
- line_err_o  out  1  valid with line_rvalid_o; any beat had rresp != OKAY, or rlast mismatch.
- m_arid  out  AXI_ID_W  constant AXI_ID.
- m_araddr  out  32  burst start address.
- m_arlen  out  8  constant 7.
- m_arsize  out  3  constant 3'b010.
- m_arburst  out  2  INCR 2'b01 (see Optional Feature).
- m_arvalid  out  1  AR valid.
- m_arready  in  1  AR ready.
- m_rid  in  AXI_ID_W  ignored.
- m_rdata  in  32  read data beat.
- m_rresp  in  2  beat response.
- m_rlast  in  1  last beat.
- m_rvalid  in  1  R valid.
- m_rready  out  1  R ready.

Behaviour:
- FSM with states IDLE, AR, R, DONE.
- Reset values:
  - state = IDLE.
  - m_arvalid, m_rready, line_rvalid_o, line_err_o = 0.
  - line_rdata_o = 0; m_araddr = 0.
  - Beat counter = 0; error flag = 0.
- IDLE:
  - If req_ren_i = 1, latch line_addr = {req_araddr_i[31:5], 5'b0}.
  - Set m_araddr = line_addr, go to AR; m_arvalid = 1 from the next cycle.
- AR:
  - m_arvalid held, and m_araddr held stable, until m_arready.
  - On handshake, go to R; beat counter = 0; error flag = 0.
- R:
  - m_rready = 1 throughout.
  - Each m_rvalid beat writes m_rdata into word slot (counter + start) mod 8, then counter++.
  - Any m_rresp != 2'b00 sets the error flag.
  - On the beat with m_rlast, go to DONE.
  - If m_rlast does not coincide with counter = 7, set the error flag; unfilled slots keep stale data.
  - A beat arriving at counter = 7 without m_rlast still goes to DONE and sets the error flag.
- DONE (exactly one cycle, then IDLE):
  - line_rvalid_o = 1 only if req_ren_i = 1 and req_araddr_i[31:5] == line_addr[31:5].
  - Otherwise the line is silently dropped (request withdrawn or redirected by flush).
  - line_err_o = error flag during the pulse; otherwise 0.
- Minimum latency, with the request seen in IDLE at cycle N and zero-wait slave:
  - arvalid at N+1, AR handshake at N+1.
  - Beats at N+2..N+9.
  - line_rvalid_o at N+10.
- Back-to-back: a new request sampled in the IDLE cycle after DONE starts immediately; no idle bubble beyond that cycle.
- req_ren_i dropping during AR or R:
  - The burst is still completed (AXI cannot abort); the AR request is not withdrawn.
  - The result is discarded at DONE per the address/ren check.
- rst mid-burst: immediate return to IDLE, all outputs to reset values. The interconnect is reset on the same rst, so no outstanding-burst drain is needed.
- line_rdata_o is a register, stable from DONE until overwritten by the next burst's beats.

Optional Feature:
- Macro CRITICAL_WORD_FIRST_EN.
- Defined:
  - m_arburst = WRAP 2'b10; m_araddr = {req_araddr_i[31:2], 2'b00}.
  - start = req_araddr_i[4:2]; beat k lands in slot (start+k) mod 8.
- Undefined:
  - m_arburst = INCR 2'b01; m_araddr = line_addr; start = 0.
- Line layout at line_rvalid_o is identical in both builds.

Decomposition:
- Shared package (or existing defines header) holds:
  - AXI_BURST_INCR / AXI_BURST_WRAP; AXI_RESP_OKAY; AXI_SIZE_4B.
  - LINE_WORDS; line-bus width; FSM state encoding.
- No sub-module needed; a line-assembly register bank with slot-index write is kept inline.

Test Plan:
- Hit-free refill, INCR: ren=1, addr=0x1FC0_0024; zero-wait slave returns words 0xA0..0xA7 -> m_araddr=0x1FC0_0020, arlen=7; line_rvalid_o pulse at cycle N+10; word i = 0xA0+i; err=0.
- AR backpressure: m_arready low 5 cycles -> m_arvalid and m_araddr held stable; pulse delayed exactly 5 cycles.
- Withdrawn request: ren dropped during beat 3 -> burst completes (8 beats accepted); line_rvalid_o stays 0; FSM back to IDLE.
- Error response: beat 5 rresp=2'b10 -> line_rvalid_o=1 with line_err_o=1; next clean burst reports err=0.
- Early rlast: rlast on beat 6 -> DONE after 6 beats; line_err_o=1.
- Critical word first (macro defined): addr 0x0000_0014 -> m_araddr=0x14, arburst=WRAP; data 0xB0..0xB7 in beat order -> slot 5 = 0xB0, slot 4 = 0xB7.
- Reset mid-R: rst at beat 4 -> next cycle arvalid=0, rready=0, rvalid_o=0; a fresh request then completes normally.
